keycode_event_fifo: RTL and testbench

- Sits directly downstream of the SoC keycode PIO output (8-bit USB HID keycode written by the NIOS II USB keyboard driver).
- Debounces changes in that keycode and turns them into timestamp-free MAKE/BREAK/REPEAT events.
- Buffers events in a small first-word-fall-through (FWFT) FIFO with a valid/ready interface, consumed by game/motion logic.

---
 rtl/keycode_pkg.sv | 29 ++
 rtl/event_fifo.sv | 49 ++++
 rtl/keycode_event_fifo.sv | 117 +++++++++++
 tb/tb_keycode_event_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// keycode_pkg: shared event, state and HID keycode definitions for the keycode event path
package keycode_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_MAKE   = 2'b01,
    EV_BREAK  = 2'b10,
    EV_REPEAT = 2'b11
  } ev_type_t;

  typedef struct packed {
    ev_type_t   kind;
    logic [7:0] code;
  } event_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_BREAK,
    S_MAKE
  } state_t;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;

endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through FIFO with sticky overflow; a push while full is admitted only alongside a pop
module event_fifo
  import keycode_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = event_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  input  logic                     clr_overflow,
  output logic                     valid,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           full, do_pop, do_push, drop;

  assign valid   = count != '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = valid ? mem[rptr] : '0;

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= do_push ? wptr + 1'b1 : wptr;
      rptr     <= do_pop ? rptr + 1'b1 : rptr;
      count    <= (do_push && !do_pop) ? count + 1'b1 :
                  (do_pop && !do_push) ? count - 1'b1 : count;
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end

endmodule

// File: rtl/keycode_event_fifo.sv
// keycode_event_fifo: debounces the PIO keycode into MAKE/BREAK/REPEAT events buffered in a FWFT FIFO
module keycode_event_fifo
  import keycode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int DEPTH         = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 keycode_in,
  output logic                       ev_valid,
  output logic [1:0]                 ev_type,
  output logic [7:0]                 ev_code,
  input  logic                       ev_ready,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [7:0]    SC = 8'(STABLE_CYCLES);
  localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP = RW'(REPEAT_PERIOD);

  state_t        state, state_n;
  logic [7:0]    candidate, counter;
  logic [7:0]    cur_code, cur_n, old_code, old_n, new_code, new_n;
  logic [RW-1:0] rpt_cnt, rpt_n;
  logic          accept, push;
  event_t        push_ev, head;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      candidate <= '0;
      counter   <= '0;
    end else if (keycode_in != candidate) begin
      candidate <= keycode_in;
      counter   <= 8'd1;
    end else begin
      counter   <= counter == SC ? counter : counter + 1'b1;
    end

  assign accept = counter == SC && candidate != cur_code && (state == S_IDLE || state == S_HELD);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= S_IDLE;
      cur_code <= '0;
      old_code <= '0;
      new_code <= '0;
      rpt_cnt  <= '0;
    end else begin
      state    <= state_n;
      cur_code <= cur_n;
      old_code <= old_n;
      new_code <= new_n;
      rpt_cnt  <= rpt_n;
    end

  always_comb begin
    state_n = state;
    cur_n   = cur_code;
    old_n   = old_code;
    new_n   = new_code;
    rpt_n   = rpt_cnt;
    push    = 1'b0;
    push_ev = '0;
    case (state)
      S_IDLE: if (accept) begin
        new_n   = candidate;
        state_n = S_MAKE;
      end
      S_HELD: if (accept) begin
        old_n   = cur_code;
        new_n   = candidate;
        state_n = S_BREAK;
      end else if (REPEAT_DELAY != 0) begin
        push    = rpt_cnt == RW'(1);
        push_ev = '{EV_REPEAT, cur_code};
        rpt_n   = rpt_cnt == RW'(1) ? RP : rpt_cnt - 1'b1;
      end
      S_BREAK: begin
        push    = 1'b1;
        push_ev = '{EV_BREAK, old_code};
        cur_n   = new_code != '0 ? cur_code : '0;
        state_n = new_code != '0 ? S_MAKE : S_IDLE;
      end
      S_MAKE: begin
        push    = 1'b1;
        push_ev = '{EV_MAKE, new_code};
        cur_n   = new_code;
        rpt_n   = RD;
        state_n = S_HELD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  event_fifo #(.DEPTH(DEPTH), .T(event_t)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .din          (push_ev),
    .pop          (ev_ready),
    .clr_overflow (clr_overflow),
    .valid        (ev_valid),
    .dout         (head),
    .count        (ev_count),
    .overflow     (overflow)
  );

  assign ev_type = head.kind;
  assign ev_code = head.code;

endmodule

// File: tb/tb_keycode_event_fifo.sv
// tb_keycode_event_fifo: directed and random keycode streams checked every cycle against a queue-based event model
module tb_keycode_event_fifo;
  import keycode_pkg::*;

  localparam int SC = 4;
  localparam int RD = 20;
  localparam int RP = 10;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode_in;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic [7:0] ev_code;
  logic       ev_ready;
  logic [2:0] ev_count;
  logic       overflow;
  logic       clr_overflow;

  keycode_event_fifo #(
    .STABLE_CYCLES (SC),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .DEPTH         (DP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keycode_in   (keycode_in),
    .ev_valid     (ev_valid),
    .ev_type      (ev_type),
    .ev_code      (ev_code),
    .ev_ready     (ev_ready),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [9:0] q[$];
  logic [9:0] pending[$];
  logic [7:0] prev, cur;
  int         run, make_t, t;
  bit         ovf;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    pending.delete();
    prev   = 8'h00;
    cur    = 8'h00;
    run    = 0;
    make_t = 0;
    ovf    = 1'b0;
  endtask

  task automatic model_step();
    logic [9:0] e;
    bit has_e, pop, drop;
    int qs;
    e     = '0;
    has_e = 1'b0;
    qs    = q.size();
    pop   = ev_ready && qs > 0;
    if (pending.size() > 0) begin
      e     = pending.pop_front();
      has_e = 1'b1;
      if (e[9:8] == EV_MAKE) make_t = t;
    end else if (run >= SC && prev != cur) begin
      if (cur != 8'h00) pending.push_back({EV_BREAK, cur});
      if (prev != 8'h00) pending.push_back({EV_MAKE, prev});
      cur = prev;
    end else if (cur != 8'h00 && t - make_t >= RD && (t - make_t - RD) % RP == 0) begin
      e     = {EV_REPEAT, cur};
      has_e = 1'b1;
    end
    if (keycode_in != prev) begin
      prev = keycode_in;
      run  = 1;
    end else if (run < SC) run++;
    if (pop) void'(q.pop_front());
    drop = has_e && !(qs < DP || pop);
    if (has_e && !drop) q.push_back(e);
    ovf = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf);
    t++;
  endtask

  task automatic compare();
    check("valid", int'(ev_valid), int'(q.size() != 0));
    check("count", int'(ev_count), q.size());
    check("overflow", int'(overflow), int'(ovf));
    check("type", int'(ev_type), q.size() != 0 ? int'(q[0][9:8]) : 0);
    check("code", int'(ev_code), q.size() != 0 ? int'(q[0][7:0]) : 0);
  endtask

  task automatic cyc(input logic [7:0] k, input bit rdy, input bit clr, input int n);
    for (int i = 0; i < n; i++) begin
      compare();
      keycode_in   = k;
      ev_ready     = rdy;
      clr_overflow = clr;
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  logic [7:0] keys [5];

  initial begin
    keys = '{KEY_NONE, KEY_W, KEY_A, KEY_S, KEY_D};
    t            = 0;
    keycode_in   = 8'h00;
    ev_ready     = 1'b1;
    clr_overflow = 1'b0;
    @(negedge clk);
    do_reset();
    cyc(KEY_W, 1, 0, 7);
    do_reset();
    cyc(KEY_W, 1, 0, 8);
    cyc(KEY_NONE, 1, 0, 8);
    cyc(KEY_A, 1, 0, 3);
    cyc(KEY_NONE, 1, 0, 6);
    cyc(KEY_A, 1, 0, 8);
    cyc(KEY_D, 1, 0, 8);
    cyc(KEY_NONE, 1, 0, 8);
    cyc(KEY_S, 1, 0, 50);
    cyc(KEY_NONE, 1, 0, 20);
    cyc(KEY_A, 0, 0, 6);
    cyc(KEY_D, 0, 0, 7);
    cyc(KEY_NONE, 0, 0, 7);
    cyc(KEY_W, 0, 0, 7);
    check("ovf_set", int'(overflow), 1);
    check("ovf_head", int'(ev_code), int'(KEY_A));
    cyc(KEY_W, 1, 0, 6);
    cyc(KEY_W, 1, 1, 1);
    cyc(KEY_W, 1, 0, 2);
    cyc(KEY_NONE, 0, 0, 6);
    cyc(KEY_A, 0, 0, 6);
    cyc(KEY_D, 0, 0, 7);
    cyc(KEY_NONE, 0, 0, 5);
    cyc(KEY_NONE, 1, 0, 1);
    cyc(KEY_NONE, 0, 0, 3);
    check("full_pp_count", int'(ev_count), 4);
    check("full_pp_ovf", int'(overflow), 0);
    cyc(KEY_NONE, 1, 0, 8);
    for (int s = 0; s < 300; s++)
      cyc(keys[$urandom_range(0, 4)], $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(1, 30));
    cyc(KEY_NONE, 1, 1, 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
